// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the up/down modulo counter
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Values are carried at 32 bits so one helper serves every counter width.
    function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max_v);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable divider producing one step per PRESCALE enabled cycles
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_direct
            logic unused_ok;
            assign unused_ok = ^{clk, reset, clear};
            assign step      = enable;
        end else begin : g_div
            localparam int DW = $clog2(PRESCALE);
            localparam logic [DW-1:0] LAST = DW'(PRESCALE - 1);

            logic [DW-1:0] div_q, div_d;

            assign step = enable && (div_q == LAST);

            // Clear wins over a coincident step so a load restarts the phase.
            always_comb begin
                div_d = div_q;
                if (clear) begin
                    div_d = '0;
                end else if (enable) begin
                    div_d = step ? '0 : div_q + DW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down modulo counter with wrap/saturate, load and prescaler
// Optional compare output enabled by UPDOWN_COUNTER_CMP_EN.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
`ifdef UPDOWN_COUNTER_CMP_EN
    ,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max_q, at_min_q;
    cnt_mode_e        mode_e;

    assign mode_e       = cnt_mode_e'(mode);
    assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .step   (step)
    );

    // Boundaries are compared explicitly because MAX_COUNT may sit below 2**WIDTH-1.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (up) begin
                if (count_q == MAX_V) begin
                    if (mode_e == CNT_WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (mode_e == CNT_WRAP) begin
                        count_d = MAX_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            at_max_q <= (count_d == MAX_V);
            at_min_q <= (count_d == '0);
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

`ifdef UPDOWN_COUNTER_CMP_EN
    logic cmp_hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_hit_q <= (cmp_val == '0);
        end else begin
            cmp_hit_q <= (count_d == cmp_val);
        end
    end

    assign cmp_hit = cmp_hit_q;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - scoreboard bench for updown_counter_mod across three configurations
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset, enable, up, mode, load;
    logic [3:0] lv4, cmp4;
    logic [7:0] lv8, cmp8;
    logic [3:0] cnt_a, cnt_p;
    logic [7:0] cnt_d;
    logic       max_a, min_a, wrap_a, hit_a;
    logic       max_p, min_p, wrap_p, hit_p;
    logic       max_d, min_d, wrap_d, hit_d;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int cnt;
        bit mx;
        bit mn;
        bit wr;
        bit hit;
    } exp_t;

    exp_t q_a[$], q_p[$], q_d[$];
    int   ma_c = 0, ma_v = 0, mp_c = 0, mp_v = 0, md_c = 0, md_v = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode), .load(load),
        .load_val(lv4), .count(cnt_a), .at_max(max_a), .at_min(min_a), .wrap(wrap_a)
`ifdef UPDOWN_COUNTER_CMP_EN
        , .cmp_val(cmp4), .cmp_hit(hit_a)
`endif
    );

    updown_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) dut_p (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode), .load(load),
        .load_val(lv4), .count(cnt_p), .at_max(max_p), .at_min(min_p), .wrap(wrap_p)
`ifdef UPDOWN_COUNTER_CMP_EN
        , .cmp_val(cmp4), .cmp_hit(hit_p)
`endif
    );

    updown_counter_mod dut_d (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode), .load(load),
        .load_val(lv8), .count(cnt_d), .at_max(max_d), .at_min(min_d), .wrap(wrap_d)
`ifdef UPDOWN_COUNTER_CMP_EN
        , .cmp_val(cmp8), .cmp_hit(hit_d)
`endif
    );

`ifndef UPDOWN_COUNTER_CMP_EN
    assign hit_a = 1'b0;
    assign hit_p = 1'b0;
    assign hit_d = 1'b0;
`endif

    // Reference behaviour of one counter for the current cycle's inputs.
    function automatic void mstep(inout int cnt, inout int div, output bit wr,
                                  input int mx, input int pres, input int lv);
        wr = 1'b0;
        if (reset) begin
            cnt = 0; div = 0;
        end else if (load) begin
            cnt = (lv > mx) ? mx : lv; div = 0;
        end else if (enable) begin
            if (div == pres - 1) begin
                div = 0;
                if (up) begin
                    if (cnt == mx) begin
                        if (!mode) begin cnt = 0; wr = 1'b1; end
                    end else cnt = cnt + 1;
                end else begin
                    if (cnt == 0) begin
                        if (!mode) begin cnt = mx; wr = 1'b1; end
                    end else cnt = cnt - 1;
                end
            end else begin
                div = div + 1;
            end
        end
    endfunction

    task automatic tick();
        exp_t e;
        bit   w;
        mstep(ma_c, ma_v, w, 9, 1, int'(lv4));
        e.cnt = ma_c; e.mx = (ma_c == 9); e.mn = (ma_c == 0); e.wr = w; e.hit = (ma_c == int'(cmp4));
        q_a.push_back(e);
        mstep(mp_c, mp_v, w, 9, 3, int'(lv4));
        e.cnt = mp_c; e.mx = (mp_c == 9); e.mn = (mp_c == 0); e.wr = w; e.hit = (mp_c == int'(cmp4));
        q_p.push_back(e);
        mstep(md_c, md_v, w, 255, 1, int'(lv8));
        e.cnt = md_c; e.mx = (md_c == 255); e.mn = (md_c == 0); e.wr = w; e.hit = (md_c == int'(cmp8));
        q_d.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; mode = 1'b0;
        tick();
        reset = 1'b0;
        q_a.delete(); q_p.delete(); q_d.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; enable = 1'b1; up = 1'b1; mode = 1'b0; load = 1'b0;
        lv4 = 4'd0; lv8 = 8'd0; cmp4 = 4'd0; cmp8 = 8'd0;
        repeat (2) begin
            tick();
            e = q_a.pop_front(); void'(q_p.pop_front()); void'(q_d.pop_front());
            checks++;
            if ({cnt_a, max_a, min_a, wrap_a} !== {4'(e.cnt), e.mx, e.mn, e.wr}) begin
                failures++;
                $display("FAIL reset_a got=%h/%b%b%b want=%h/%b%b%b", cnt_a, max_a, min_a, wrap_a, e.cnt, e.mx, e.mn, e.wr);
            end
        end
        checks++;
        if ({cnt_p, max_p, min_p, wrap_p, cnt_d, max_d, min_d, wrap_d} !== {4'd0, 3'b010, 8'd0, 3'b010}) begin
            failures++;
            $display("FAIL reset_pd got=%h %b%b%b %h %b%b%b want=0 010 0 010", cnt_p, max_p, min_p, wrap_p, cnt_d, max_d, min_d, wrap_d);
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        exp_t e;
        int   wraps = 0;
        restart();
        enable = 1'b1; up = 1'b1; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = q_a.pop_front();
            checks++;
            if ({cnt_a, max_a, min_a, wrap_a} !== {4'(e.cnt), e.mx, e.mn, e.wr}) begin
                failures++;
                $display("FAIL wrap_up step%0d got=%0d/%b%b%b want=%0d/%b%b%b", i, cnt_a, max_a, min_a, wrap_a, e.cnt, e.mx, e.mn, e.wr);
            end
            if (wrap_a) wraps++;
            if (i == 8) begin
                checks++;
                if (!(cnt_a === 4'd9 && max_a === 1'b1)) begin
                    failures++;
                    $display("FAIL at_max_9 got=%0d max=%b want=9 max=1", cnt_a, max_a);
                end
            end
        end
        checks++;
        if (!(cnt_a === 4'd0 && wrap_a === 1'b1 && wraps == 1)) begin
            failures++;
            $display("FAIL wrap_pulse got cnt=%0d wrap=%b pulses=%0d want cnt=0 wrap=1 pulses=1", cnt_a, wrap_a, wraps);
        end
    endtask

    task automatic test_sat_down();
        exp_t e;
        int   seq[5] = '{2, 1, 0, 0, 0};
        restart();
        lv4 = 4'd3; load = 1'b1;
        tick();
        void'(q_a.pop_front());
        load = 1'b0; enable = 1'b1; up = 1'b0; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = q_a.pop_front();
            checks++;
            if ({cnt_a, max_a, min_a, wrap_a} !== {4'(e.cnt), e.mx, e.mn, e.wr} || cnt_a !== 4'(seq[i])) begin
                failures++;
                $display("FAIL sat_down step%0d got=%0d/%b%b%b want=%0d/%b%b%b", i, cnt_a, max_a, min_a, wrap_a, seq[i], e.mx, e.mn, e.wr);
            end
        end
    endtask

    task automatic test_prescale();
        exp_t e;
        bit   en_pat[12] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        restart();
        up = 1'b1; mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            enable = en_pat[i];
            tick();
            e = q_p.pop_front();
            checks++;
            if ({cnt_p, max_p, min_p, wrap_p} !== {4'(e.cnt), e.mx, e.mn, e.wr}) begin
                failures++;
                $display("FAIL prescale cyc%0d got=%0d/%b%b%b want=%0d/%b%b%b", i, cnt_p, max_p, min_p, wrap_p, e.cnt, e.mx, e.mn, e.wr);
            end
        end
        checks++;
        if (cnt_p !== 4'd2) begin
            failures++;
            $display("FAIL prescale_phase got=%0d want=2", cnt_p);
        end
    endtask

    task automatic test_load();
        exp_t e;
        restart();
        lv4 = 4'd12; load = 1'b1;
        tick();
        e = q_a.pop_front();
        checks++;
        if ({cnt_a, max_a, wrap_a} !== {4'd9, 1'b1, 1'b0} || cnt_a !== 4'(e.cnt)) begin
            failures++;
            $display("FAIL load_clamp got=%0d max=%b wrap=%b want=9 max=1 wrap=0", cnt_a, max_a, wrap_a);
        end
        restart();
        enable = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load = (i == 2);
            lv4  = 4'd4;
            tick();
            e = q_p.pop_front();
            checks++;
            if ({cnt_p, max_p, min_p, wrap_p} !== {4'(e.cnt), e.mx, e.mn, e.wr}) begin
                failures++;
                $display("FAIL load_step cyc%0d got=%0d/%b%b%b want=%0d/%b%b%b", i, cnt_p, max_p, min_p, wrap_p, e.cnt, e.mx, e.mn, e.wr);
            end
        end
        checks++;
        if (cnt_p !== 4'd5) begin
            failures++;
            $display("FAIL load_divclear got=%0d want=5", cnt_p);
        end
        load = 1'b0;
    endtask

    task automatic test_default_wrap();
        exp_t e;
        restart();
        lv8 = 8'd255; load = 1'b1;
        tick();
        void'(q_d.pop_front());
        load = 1'b0; enable = 1'b1; up = 1'b1; mode = 1'b0;
        tick();
        e = q_d.pop_front();
        checks++;
        if ({cnt_d, wrap_d, min_d} !== {8'd0, 1'b1, 1'b1} || e.wr !== 1'b1) begin
            failures++;
            $display("FAIL default_wrap got=%0d wrap=%b min=%b want=0 wrap=1 min=1", cnt_d, wrap_d, min_d);
        end
        load = 1'b1;
        tick();
        void'(q_d.pop_front());
        load = 1'b0; reset = 1'b1;
        tick();
        e = q_d.pop_front();
        checks++;
        if ({cnt_d, wrap_d, min_d} !== {8'd0, 1'b0, 1'b1} || e.wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_beats_wrap got=%0d wrap=%b min=%b want=0 wrap=0 min=1", cnt_d, wrap_d, min_d);
        end
        reset = 1'b0;
    endtask

`ifdef UPDOWN_COUNTER_CMP_EN
    task automatic test_cmp();
        exp_t e;
        restart();
        cmp4 = 4'd5; enable = 1'b1; up = 1'b1; mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = q_a.pop_front();
            checks++;
            if (hit_a !== e.hit || hit_a !== (cnt_a == 4'd5)) begin
                failures++;
                $display("FAIL cmp_hit cyc%0d cnt=%0d got=%b want=%b", i, cnt_a, hit_a, e.hit);
            end
        end
        enable = 1'b0;
        cmp4   = cnt_a;
        tick();
        e = q_a.pop_front();
        checks++;
        if (hit_a !== 1'b1 || e.hit !== 1'b1) begin
            failures++;
            $display("FAIL cmp_retarget got=%b want=1", hit_a);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_prescale();
        test_load();
        test_default_wrap();
`ifdef UPDOWN_COUNTER_CMP_EN
        test_cmp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
